// File: rtl/k_merge_p2.sv
// Phase-2 KNN merge: pops the NUM_CH phase-1 sorter heads in ascending order and
// streams the K smallest entries over valid/ready. Optional: KMERGE_SKIP_FILLER_EN.
//
// state  | meaning
// IDLE   | waiting for start, all outputs idle
// SELECT | pick minimum head, register it, pop that channel
// EMIT   | present registered entry until accepted
// FINISH | one-cycle mergeDone pulse
module k_merge_p2 #(
  parameter int DATA_WIDTH = 32,
  parameter int VAL_WIDTH  = 32,
  parameter int NUM_CH     = 1,
  parameter int K          = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_CH*DATA_WIDTH-1:0] chNameIn,
  input  logic [NUM_CH*VAL_WIDTH-1:0]  chValueIn,
  output logic [NUM_CH-1:0]            chOutEn,
  output logic                         resultValid,
  input  logic                         resultReady,
  output logic [DATA_WIDTH-1:0]        resultName,
  output logic [VAL_WIDTH-1:0]         resultValue,
  output logic                         mergeDone,
  output logic                         busy
);

  localparam int CW = $clog2(K + 1);
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, SELECT, EMIT, FINISH} state_t;

  state_t              state, stateNext;
  logic [CW-1:0]       emitted;
  logic [SW-1:0]       sel;
  logic [VAL_WIDTH-1:0]  minVal;
  logic [DATA_WIDTH-1:0] minName;
  logic                skipFiller;

  // Strict less-than keeps the lowest channel index on ties.
  always_comb begin
    sel     = '0;
    minVal  = chValueIn[0 +: VAL_WIDTH];
    minName = chNameIn[0 +: DATA_WIDTH];
    for (int c = 1; c < NUM_CH; c++) begin
      if (chValueIn[c*VAL_WIDTH +: VAL_WIDTH] < minVal) begin
        sel     = SW'(c);
        minVal  = chValueIn[c*VAL_WIDTH +: VAL_WIDTH];
        minName = chNameIn[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef KMERGE_SKIP_FILLER_EN
  // A filler winner means every remaining head is filler as well.
  assign skipFiller = (minName == {DATA_WIDTH{1'b1}});
`else
  assign skipFiller = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = SELECT;
      SELECT:  stateNext = skipFiller ? FINISH : EMIT;
      EMIT:    if (resultReady) stateNext = (emitted == CW'(K)) ? FINISH : SELECT;
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      emitted     <= '0;
      resultName  <= '0;
      resultValue <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && start) begin
        emitted <= '0;
      end
      if (state == SELECT && !skipFiller) begin
        emitted     <= emitted + CW'(1);
        resultName  <= minName;
        resultValue <= minVal;
      end
    end
  end

  assign chOutEn     = (state == SELECT && !skipFiller) ? (NUM_CH'(1) << sel) : '0;
  assign resultValid = (state == EMIT);
  assign mergeDone   = (state == FINISH);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_k_merge_p2.sv
// Directed bench for k_merge_p2 with NUM_CH=2, K=3 and a behavioural phase-1 sorter
// model; follows KMERGE_SKIP_FILLER_EN for the filler case.
module tb_k_merge_p2;
  localparam int NUM_CH = 2;
  localparam int K      = 3;
  localparam logic [31:0] FILL = 32'hFFFFFFFF;

  logic              clk = 1'b0;
  logic              reset, start, resultReady, sorterClr;
  logic [NUM_CH*32-1:0] chNameIn, chValueIn;
  logic [NUM_CH-1:0] chOutEn;
  logic              resultValid, mergeDone, busy;
  logic [31:0]       resultName, resultValue;

  logic [31:0] listVal  [NUM_CH][K];
  logic [31:0] listName [NUM_CH][K];
  int          ptr [NUM_CH];
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  k_merge_p2 #(.DATA_WIDTH(32), .VAL_WIDTH(32), .NUM_CH(NUM_CH), .K(K)) dut (
    .clk(clk), .reset(reset), .start(start),
    .chNameIn(chNameIn), .chValueIn(chValueIn), .chOutEn(chOutEn),
    .resultValid(resultValid), .resultReady(resultReady),
    .resultName(resultName), .resultValue(resultValue),
    .mergeDone(mergeDone), .busy(busy)
  );

  // Phase-1 sorter model: head is combinational from the pointer, pop on outEn.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset || sorterClr) ptr[c] <= 0;
      else if (chOutEn[c])    ptr[c] <= ptr[c] + 1;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      chValueIn[c*32 +: 32] = (ptr[c] < K) ? listVal[c][ptr[c]]  : FILL;
      chNameIn[c*32 +: 32]  = (ptr[c] < K) ? listName[c][ptr[c]] : FILL;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadLists(input logic [31:0] v0 [K], input logic [31:0] n0 [K],
                           input logic [31:0] v1 [K], input logic [31:0] n1 [K]);
    for (int i = 0; i < K; i++) begin
      listVal[0][i] = v0[i]; listName[0][i] = n0[i];
      listVal[1][i] = v1[i]; listName[1][i] = n1[i];
    end
    sorterClr = 1'b1;
    tick();
    sorterClr = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One SELECT cycle (pop check) then the EMIT cycle (entry check); ready assumed high.
  task automatic expectEntry(input string tag, input logic [1:0] oh,
                             input logic [31:0] v, input logic [31:0] n);
    check({tag, ".pop"}, chOutEn, oh);
    check({tag, ".busy"}, busy, 1'b1);
    tick();
    check({tag, ".valid"}, resultValid, 1'b1);
    check({tag, ".value"}, resultValue, v);
    check({tag, ".name"}, resultName, n);
    check({tag, ".noPop"}, chOutEn, 2'b00);
    tick();
  endtask

  task automatic expectFinish(input string tag);
    check({tag, ".done"}, mergeDone, 1'b1);
    check({tag, ".validLow"}, resultValid, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".idle"}, busy, 1'b0);
    check({tag, ".doneLow"}, mergeDone, 1'b0);
    tick();
    check({tag, ".startIgnored"}, busy, 1'b0);
  endtask

  initial begin
    logic [31:0] a [K], b [K], c [K], d [K];
    reset = 1'b1; start = 1'b0; resultReady = 1'b1; sorterClr = 1'b0;
    for (int i = 0; i < K; i++) begin
      listVal[0][i] = '0; listName[0][i] = '0; listVal[1][i] = '0; listName[1][i] = '0;
    end
    tick(); tick();
    reset = 1'b0;
    check("rst.busy", busy, 1'b0);
    check("rst.valid", resultValid, 1'b0);
    check("rst.pop", chOutEn, 2'b00);
    check("rst.done", mergeDone, 1'b0);
    check("rst.name", resultName, 32'd0);
    check("rst.value", resultValue, 32'd0);

    // Basic merge: 5,7,8 with pops 01,10,10, mergeDone at start+7.
    a = '{5, 9, 20};  b = '{100, 101, 102};
    c = '{7, 8, 30};  d = '{200, 201, 202};
    loadLists(a, b, c, d);
    pulseStart();
    expectEntry("basic0", 2'b01, 5, 100);
    expectEntry("basic1", 2'b10, 7, 200);
    expectEntry("basic2", 2'b10, 8, 201);
    expectFinish("basic");

    // Equal values: lowest channel wins first.
    a = '{4, 9, 20};  b = '{10, 11, 12};
    c = '{4, 8, 30};  d = '{21, 22, 23};
    loadLists(a, b, c, d);
    pulseStart();
    expectEntry("tie0", 2'b01, 4, 10);
    expectEntry("tie1", 2'b10, 4, 21);
    expectEntry("tie2", 2'b10, 8, 22);
    expectFinish("tie");

    // Backpressure: ready low for 5 EMIT cycles, then high.
    a = '{5, 9, 20};  b = '{100, 101, 102};
    c = '{7, 8, 30};  d = '{200, 201, 202};
    loadLists(a, b, c, d);
    resultReady = 1'b0;
    pulseStart();
    check("bp.pop", chOutEn, 2'b01);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", resultValid, 1'b1);
      check("bp.value", resultValue, 32'd5);
      check("bp.name", resultName, 32'd100);
      check("bp.noPop", chOutEn, 2'b00);
      tick();
    end
    resultReady = 1'b1;
    check("bp.stillValid", resultValid, 1'b1);
    check("bp.stillValue", resultValue, 32'd5);
    tick();
    expectEntry("bp1", 2'b10, 7, 200);
    expectEntry("bp2", 2'b10, 8, 201);
    expectFinish("bp");

    // Reset during the second EMIT, then a full fresh merge.
    loadLists(a, b, c, d);
    pulseStart();
    expectEntry("rm0", 2'b01, 5, 100);
    check("rm1.pop", chOutEn, 2'b10);
    tick();
    check("rm1.value", resultValue, 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rm.busy", busy, 1'b0);
    check("rm.valid", resultValid, 1'b0);
    check("rm.name", resultName, 32'd0);
    check("rm.value", resultValue, 32'd0);
    check("rm.pop", chOutEn, 2'b00);
    pulseStart();
    expectEntry("rf0", 2'b01, 5, 100);
    expectEntry("rf1", 2'b10, 7, 200);
    expectEntry("rf2", 2'b10, 8, 201);
    expectFinish("rf");

    // One channel supplies everything.
    a = '{1, 2, 3};    b = '{31, 32, 33};
    c = '{50, 60, 70}; d = '{41, 42, 43};
    loadLists(a, b, c, d);
    pulseStart();
    expectEntry("one0", 2'b01, 1, 31);
    expectEntry("one1", 2'b01, 2, 32);
    expectEntry("one2", 2'b01, 3, 33);
    expectFinish("one");

    // Filler handling.
    a = '{6, FILL, FILL};    b = '{60, FILL, FILL};
    c = '{FILL, FILL, FILL}; d = '{FILL, FILL, FILL};
    loadLists(a, b, c, d);
    pulseStart();
    expectEntry("fill0", 2'b01, 6, 60);
`ifdef KMERGE_SKIP_FILLER_EN
    check("fillSkip.pop", chOutEn, 2'b00);
    check("fillSkip.busy", busy, 1'b1);
    tick();
    expectFinish("fillSkip");
`else
    expectEntry("fill1", 2'b01, FILL, FILL);
    expectEntry("fill2", 2'b01, FILL, FILL);
    expectFinish("fill");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/k_merge_p2.md
# k_merge_p2

Phase-2 merge block for the KNN accelerator. Reads the per-channel sorted K-nearest lists held by the NUM_CH phase-1 sorters: it inspects each sorter's current head (name/value at its output pointer) and pulses that sorter's output-enable to advance it. It merges these lists into a single global ascending list of the K smallest distances and streams that list out over a valid/ready interface to the AXI-side result logic.

## Interface
- DATA_WIDTH, 32, name width of each entry. Fixed at 32 to match the phase-1 name output.
- VAL_WIDTH, 32, distance value width.
- NUM_CH, 1, number of phase-1 sorter channels. Range 1..16.
- K, 1, number of neighbours. Equals the phase-1 K.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a merge. Ignored unless the block is in IDLE.
- chNameIn  in  NUM_CH*32  head names. Channel c occupies bits [c*32 +: 32].
- chValueIn  in  NUM_CH*VAL_WIDTH  head values. Channel c occupies bits [c*VAL_WIDTH +: VAL_WIDTH].
- chOutEn  out  NUM_CH  one-hot pop pulse to the phase-1 sorters' outEn inputs.
- resultValid  out  1  resultName/resultValue hold a merged entry.
- resultReady  in  1  downstream accepts the entry.
- resultName  out  32  merged entry name.
- resultValue  out  VAL_WIDTH  merged entry value.
- mergeDone  out  1  one-cycle pulse after the final entry has been transferred.
- busy  out  1  high in every state except IDLE.

## Operation
- The phase-1 sorters advance their pointer on the clk edge where done && outEn. Their head output is combinational from that pointer, so a popped channel presents its next entry in the cycle after the chOutEn pulse.
- The top level holds the phase-1 done high for the whole merge. This block does not check it.
- FSM states are IDLE, SELECT, EMIT and FINISH.
  - IDLE: all outputs are idle. A start pulse moves to SELECT and clears the emitted counter.
  - SELECT (exactly 1 cycle):
    - Compares all NUM_CH head values and picks the minimum. Ties go to the lowest channel index; the comparison is unsigned.
    - Registers the winning name and value into resultName/resultValue.
    - Drives chOutEn[sel]=1 for this cycle only.
    - Increments the emitted counter.
    - Moves to EMIT.
  - EMIT: resultValid=1, with name and value held stable. On resultValid && resultReady:
    - go to FINISH if emitted==K;
    - otherwise go to SELECT.
  - FINISH (1 cycle): mergeDone=1, then go to IDLE.
- The emitted counter is $clog2(K+1) bits wide and never exceeds K.
- Channel exhaustion cannot occur: a channel can contribute at most K entries, and the merge stops at K. No per-channel counters are kept.
- Filler entries (name 32'hFFFFFFFF, value all ones) are treated as ordinary entries unless the configuration macro below is defined.
- start arriving in any state other than IDLE is ignored, including a start in the FINISH cycle.
- Reset asserted mid-merge:
  - the next cycle is IDLE;
  - all outputs return to their reset values;
  - an entry presented in EMIT is dropped.
  - The top level resets the phase-1 sorters on the same reset.

## Timing
- Reset values: chOutEn=0, resultValid=0, resultName=0, resultValue=0, mergeDone=0, busy=0.
- start at cycle n gives SELECT at n+1 (with chOutEn pulsed), then resultValid from n+2.
- With resultReady held high, each entry takes 2 cycles (SELECT + EMIT). The first entry is accepted at n+2 and the K-th at n+2K.
- mergeDone is high at n+2K+1, and busy drops at n+2K+2.
- resultReady low stalls in EMIT indefinitely, with no pops issued.
- chOutEn is never asserted outside SELECT and is never more than one bit high.

## Configuration
- KMERGE_SKIP_FILLER_EN
  - Defined: in SELECT, if the winning name equals 32'hFFFFFFFF, the block issues no pop, does not increment the counter, asserts no resultValid, and goes directly to FINISH.
    - This is valid because filler is the maximum value, so every remaining head is filler too.
    - The merge may therefore emit fewer than K entries. mergeDone still pulses once.
  - Undefined: exactly K entries are always emitted, filler included.

## Test plan
- NUM_CH=2, K=3; ch0 list {5,9,20}, ch1 list {7,8,30}; resultReady=1 -> values 5,7,8 on consecutive EMIT cycles; chOutEn pulses 01,10,10; mergeDone at start+7.
- Tie case: ch0 {4,...}, ch1 {4,...}, names 10 and 21 -> first output name 10 via chOutEn=01, then ch1's 4 (name 21).
- Backpressure: hold resultReady=0 for 5 cycles in the first EMIT -> resultValid stays 1 with value and name stable, no chOutEn pulse, and the sequence resumes unchanged.
- Reset during the second EMIT -> next cycle busy=0, resultValid=0, resultName=0, resultValue=0; a fresh start then produces the full list.
- NUM_CH=2, K=3; ch0 {1,2,3}, ch1 {50,60,70} -> chOutEn=01 three times; outputs 1,2,3.
- With KMERGE_SKIP_FILLER_EN, K=3, only 1 real entry, value 6 (ch0 {6,filler,filler}, ch1 all filler) -> one output of value 6, then mergeDone with no further resultValid. Without the macro -> 6 followed by two all-ones entries.
